// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction fetch front-end.
package if_fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] NOP = '0;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      HOLD  = 2'd2,
      DRAIN = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/if_fetch_hold_buf.sv
// One-entry buffer for an instruction that was accepted from memory while
// the pipeline was stalled.
module if_fetch_hold_buf
   import if_fetch_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            load_i,
   input  logic            clear_i,
   input  logic [XLEN-1:0] data_i,
   output logic            valid_o,
   output logic [XLEN-1:0] data_o
);

   logic            valid_q;
   logic [XLEN-1:0] data_q;

   // Clear wins over load so that a branch always drops the buffered word.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= NOP;
      end else if (clear_i) begin
         valid_q <= 1'b0;
         data_q  <= NOP;
      end else if (load_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front-end: PC, imem req/ack handshake, IF/ID outputs.
// Optional perf counters are enabled with the IF_FETCH_PERF_EN macro.
//
// state | meaning
// BOOT  | first cycle after reset, no request
// FETCH | requesting imem at pc
// HOLD  | word captured during stall, waiting for stall to drop
// DRAIN | finishing a request abandoned by a branch, data discarded
module if_fetch_unit
   import if_fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'd0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] pc_next_out,
   output logic [XLEN-1:0] instr_out,
   output logic            instr_valid,
   output logic            flush_out
`ifdef IF_FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched,
   output logic [31:0]     perf_wait
`endif
);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] req_addr_q, req_addr_d;
   logic [XLEN-1:0] pc_next_q, pc_next_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            imem_req_q, imem_req_d;
   logic [XLEN-1:0] imem_addr_q, imem_addr_d;
   logic            hb_load, hb_clear, hb_valid, accept;
   logic [XLEN-1:0] hb_data;

   if_fetch_hold_buf u_hold_buf (
      .clk     (clk),
      .rst     (rst),
      .load_i  (hb_load),
      .clear_i (hb_clear),
      .data_i  (imem_rdata),
      .valid_o (hb_valid),
      .data_o  (hb_data)
   );

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_addr_d = req_addr_q;
      pc_next_d  = pc_next_q;
      instr_d    = instr_q;
      valid_d    = valid_q;
      hb_load    = 1'b0;
      hb_clear   = 1'b0;
      accept     = 1'b0;
      if (branch_taken) begin
         pc_d     = branch_target;
         instr_d  = NOP;
         valid_d  = 1'b0;
         hb_clear = 1'b1;
         if ((state_q == FETCH || state_q == DRAIN) && !imem_ack)
            state_d = DRAIN;
         else
            state_d = FETCH;
         if (state_q == FETCH)
            req_addr_d = pc_q;
      end else begin
         unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
               if (imem_ack) begin
                  if (stall) begin
                     hb_load = 1'b1;
                     state_d = HOLD;
                  end else begin
                     accept  = 1'b1;
                     instr_d = imem_rdata;
                     valid_d = 1'b1;
                  end
               end else if (!stall) begin
                  instr_d = NOP;
                  valid_d = 1'b0;
               end
            end
            HOLD: begin
               if (!stall) begin
                  accept   = 1'b1;
                  instr_d  = hb_data;
                  valid_d  = hb_valid;
                  hb_clear = 1'b1;
                  state_d  = FETCH;
               end
            end
            DRAIN: if (imem_ack) state_d = FETCH;
            default: state_d = BOOT;
         endcase
         if (accept) begin
            pc_d      = pc_q + 32'd1;
            pc_next_d = pc_q + 32'd1;
         end
      end
      imem_req_d  = (state_d == FETCH) || (state_d == DRAIN);
      imem_addr_d = (state_d == DRAIN) ? req_addr_d : pc_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= BOOT;
         pc_q        <= RESET_PC;
         req_addr_q  <= '0;
         pc_next_q   <= '0;
         instr_q     <= NOP;
         valid_q     <= 1'b0;
         imem_req_q  <= 1'b0;
         imem_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         pc_next_q   <= pc_next_d;
         instr_q     <= instr_d;
         valid_q     <= valid_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
      end
   end

   assign imem_req    = imem_req_q;
   assign imem_addr   = imem_addr_q;
   assign pc_next_out = pc_next_q;
   assign instr_out   = instr_q;
   assign instr_valid = valid_q;
   assign flush_out   = branch_taken;

`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_wait_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_fetched_q <= '0;
         perf_wait_q    <= '0;
      end else begin
         if (accept && valid_d)
            perf_fetched_q <= perf_fetched_q + 32'd1;
         if (imem_req_q && !imem_ack)
            perf_wait_q <= perf_wait_q + 32'd1;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_wait    = perf_wait_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: directed scenarios then random
// stall/branch/ack traffic against a program-order reference model.
module tb_if_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] pc_next_out;
   logic [31:0] instr_out;
   logic        instr_valid;
   logic        flush_out;
`ifdef IF_FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_wait;
`endif

   if_fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .imem_req      (imem_req),
      .imem_addr     (imem_addr),
      .imem_ack      (imem_ack),
      .imem_rdata    (imem_rdata),
      .pc_next_out   (pc_next_out),
      .instr_out     (instr_out),
      .instr_valid   (instr_valid),
      .flush_out     (flush_out)
`ifdef IF_FETCH_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_wait     (perf_wait)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;

   // Reference model: program-order fetch address, pending stall capture,
   // stale request left over from a redirect, and the expected IF/ID triple.
   logic [31:0] m_pc;
   logic        m_boot_done;
   logic        m_hold;
   logic [31:0] m_held;
   logic        m_drain;
   logic [31:0] m_stale;
   logic [31:0] e_pn, e_instr;
   logic        e_valid;
   int unsigned m_fetched, m_wait;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) passes++;
      else $error("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   task automatic model_reset();
      m_pc = RST_PC; m_boot_done = 1'b0; m_hold = 1'b0; m_held = '0;
      m_drain = 1'b0; m_stale = '0;
      e_pn = '0; e_instr = '0; e_valid = 1'b0;
      m_fetched = 0; m_wait = 0;
   endtask

   task automatic present(input logic [31:0] word);
      e_pn = m_pc + 32'd1; e_instr = word; e_valid = 1'b1;
      m_pc = m_pc + 32'd1;
      m_fetched++;
   endtask

   // Called at posedge+1; drives one cycle of inputs and checks the result.
   task automatic cycle(input logic st, input logic br, input logic [31:0] tgt, input logic ack);
      logic exp_req, hs;
      stall = st; branch_taken = br; branch_target = tgt; imem_ack = ack;
      imem_rdata = ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
      exp_req = m_boot_done && !m_hold;
      #1;
      chk("flush", {31'd0, flush_out}, {31'd0, br});
      chk("req", {31'd0, imem_req}, {31'd0, exp_req});
      if (exp_req) chk("addr", imem_addr, m_drain ? m_stale : m_pc);
      hs = exp_req && ack;
      if (exp_req && !ack) m_wait++;
      if (br) begin
         if (exp_req && !ack && !m_drain) begin
            m_drain = 1'b1; m_stale = m_pc;
         end else if (hs) begin
            m_drain = 1'b0;
         end
         m_pc = tgt; m_hold = 1'b0; e_valid = 1'b0; e_instr = '0;
      end else if (m_drain) begin
         if (hs) m_drain = 1'b0;
         e_valid = 1'b0; e_instr = '0;
      end else if (m_hold) begin
         if (!st) begin
            m_hold = 1'b0;
            present(m_held);
         end
      end else if (hs) begin
         if (st) begin
            m_hold = 1'b1; m_held = mem_word(m_pc);
         end else begin
            present(mem_word(m_pc));
         end
      end else if (m_boot_done && !st) begin
         e_valid = 1'b0; e_instr = '0;
      end
      m_boot_done = 1'b1;
      @(posedge clk); #1;
      chk("valid", {31'd0, instr_valid}, {31'd0, e_valid});
      chk("instr", instr_out, e_instr);
      if (e_valid) chk("pc_next", pc_next_out, e_pn);
   endtask

   initial begin
      model_reset();
      // Reset values
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk("rst_addr", imem_addr, 32'd0);
      chk("rst_pc_next", pc_next_out, 32'd0);
      chk("rst_instr", instr_out, 32'd0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      rst = 1'b0;

      // Back-to-back fetch from RESET_PC with ack held high
      repeat (6) cycle(1'b0, 1'b0, 32'd0, 1'b1);

      // Ack delayed three cycles on 0x20
      cycle(1'b0, 1'b1, 32'h20, 1'b1);
      repeat (3) cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);

      // Two-cycle stall with ack arriving during the stall
      cycle(1'b1, 1'b0, 32'd0, 1'b1);
      cycle(1'b1, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);

      // Redirect to 0x40 while a request on 0x24 is pending
      cycle(1'b0, 1'b1, 32'h24, 1'b1);
      cycle(1'b0, 1'b1, 32'h40, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("after_drain_pc_next", pc_next_out, 32'h41);

      // Branch and stall in the same cycle
      cycle(1'b1, 1'b1, 32'h80, 1'b1);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);

      // PC wrap at the top of the address space
      cycle(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      chk("wrap_pc_next", pc_next_out, 32'd0);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);

      // Asynchronous reset with a request outstanding
      cycle(1'b0, 1'b0, 32'd0, 1'b0);
      rst = 1'b1;
      #1;
      chk("async_rst_req", {31'd0, imem_req}, 32'd0);
      chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("async_rst_instr", instr_out, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      cycle(1'b0, 1'b0, 32'd0, 1'b1);
      cycle(1'b0, 1'b0, 32'd0, 1'b1);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
         cycle(($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), tgt,
               ($urandom_range(0, 2) != 0));
      end

`ifdef IF_FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_wait", perf_wait, m_wait);
`endif

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
